// File: rtl/des_round_pipe.sv
// rtl/des_round_pipe.sv - two-stage pipelined DES round with external S-box and valid/ready flow
module des_round_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_l,
  input  logic [31:0]      in_r,
  input  logic [47:0]      in_key,
  input  logic [TAG_W-1:0] in_tag,
  output logic [5:0]       sel_box0,
  output logic [5:0]       sel_box1,
  output logic [5:0]       sel_box2,
  output logic [5:0]       sel_box3,
  output logic [5:0]       sel_box4,
  output logic [5:0]       sel_box5,
  output logic [5:0]       sel_box6,
  output logic [5:0]       sel_box7,
  input  logic [3:0]       s_in0,
  input  logic [3:0]       s_in1,
  input  logic [3:0]       s_in2,
  input  logic [3:0]       s_in3,
  input  logic [3:0]       s_in4,
  input  logic [3:0]       s_in5,
  input  logic [3:0]       s_in6,
  input  logic [3:0]       s_in7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_l,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag
);

  // Stage 1 state: S-box selects plus the halves and tag riding alongside
  logic             s1_valid_q, s1_valid_d;
  logic [7:0][5:0]  sel_q, sel_d;
  logic [31:0]      l1_q, l1_d;
  logic [31:0]      r1_q, r1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // Stage 2 state: next-round halves presented downstream
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_l_q, out_l_d;
  logic [31:0]      out_r_q, out_r_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             s1_adv, s2_adv;
  logic [47:0]      e_x;
  logic [7:0][5:0]  sel_new;
  logic [31:0]      s_cat;
  logic [31:0]      f_perm;

  // Stage advance: a stage moves when it is empty or its successor moves
  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready = s1_adv;

  // E-expansion of R (bit 31 = DES bit 1), key mix, and row/column select ordering
  always_comb begin
    e_x = {in_r[0],     in_r[31:27], in_r[28:23], in_r[24:19],
           in_r[20:15], in_r[16:11], in_r[12:7],  in_r[8:3],
           in_r[4:0],   in_r[31]} ^ in_key;
    sel_new = '0;
    for (int n = 0; n < 8; n++) begin
      // b1 and b6 form the row, b2..b5 the column
      sel_new[n] = {e_x[47-6*n], e_x[42-6*n], e_x[46-6*n -: 4]};
    end
  end

  // S-box results in S1..S8 order, then P-permutation
  always_comb begin
    s_cat  = {s_in0, s_in1, s_in2, s_in3, s_in4, s_in5, s_in6, s_in7};
    f_perm = {s_cat[16], s_cat[25], s_cat[12], s_cat[11],
              s_cat[3],  s_cat[20], s_cat[4],  s_cat[15],
              s_cat[31], s_cat[17], s_cat[9],  s_cat[6],
              s_cat[27], s_cat[14], s_cat[1],  s_cat[22],
              s_cat[30], s_cat[24], s_cat[8],  s_cat[18],
              s_cat[0],  s_cat[5],  s_cat[29], s_cat[23],
              s_cat[13], s_cat[19], s_cat[2],  s_cat[26],
              s_cat[10], s_cat[21], s_cat[28], s_cat[7]};
  end

  // Next-state: data registers load only with a valid beat, so held beats keep selects stable
  always_comb begin
    s1_valid_d  = s1_valid_q;
    sel_d       = sel_q;
    l1_d        = l1_q;
    r1_d        = r1_q;
    tag1_d      = tag1_q;
    out_valid_d = out_valid_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    out_tag_d   = out_tag_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        sel_d  = sel_new;
        l1_d   = in_l;
        r1_d   = in_r;
        tag1_d = in_tag;
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_l_d   = r1_q;
        out_r_d   = l1_q ^ f_perm;
        out_tag_d = tag1_q;
      end
    end
  end

  // Pipeline registers; reset discards any in-flight beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      sel_q       <= '0;
      l1_q        <= '0;
      r1_q        <= '0;
      tag1_q      <= '0;
      out_valid_q <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      sel_q       <= sel_d;
      l1_q        <= l1_d;
      r1_q        <= r1_d;
      tag1_q      <= tag1_d;
      out_valid_q <= out_valid_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign sel_box0  = sel_q[0];
  assign sel_box1  = sel_q[1];
  assign sel_box2  = sel_q[2];
  assign sel_box3  = sel_q[3];
  assign sel_box4  = sel_q[4];
  assign sel_box5  = sel_q[5];
  assign sel_box6  = sel_q[6];
  assign sel_box7  = sel_q[7];
  assign out_valid = out_valid_q;
  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_des_round_pipe.sv
// tb/tb_des_round_pipe.sv - scoreboard bench for des_round_pipe with behavioural S-boxes
module tb_des_round_pipe;

  localparam int TAG_W = 4;

  // S1..S8, 64 entries each, entry index = {row, column}, entry 0 in the top nibble
  localparam logic [255:0] S_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAE17608DB,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  localparam int E_TAB [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                                12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                                22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid, in_ready;
  logic [31:0]      in_l, in_r;
  logic [47:0]      in_key;
  logic [TAG_W-1:0] in_tag;
  logic [5:0]       sel_box0, sel_box1, sel_box2, sel_box3, sel_box4, sel_box5, sel_box6, sel_box7;
  logic [3:0]       s_in0, s_in1, s_in2, s_in3, s_in4, s_in5, s_in6, s_in7;
  logic             out_valid, out_ready;
  logic [31:0]      out_l, out_r;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [63:0]      lr;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_in = 0;
  int   n_out = 0;
  bit   acc;

  des_round_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_key(in_key), .in_tag(in_tag),
    .sel_box0(sel_box0), .sel_box1(sel_box1), .sel_box2(sel_box2), .sel_box3(sel_box3),
    .sel_box4(sel_box4), .sel_box5(sel_box5), .sel_box6(sel_box6), .sel_box7(sel_box7),
    .s_in0(s_in0), .s_in1(s_in1), .s_in2(s_in2), .s_in3(s_in3),
    .s_in4(s_in4), .s_in5(s_in5), .s_in6(s_in6), .s_in7(s_in7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_l(out_l), .out_r(out_r), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input int n, input logic [5:0] sel);
    logic [255:0] t;
    t = S_TAB[n];
    return t[255-4*int'(sel) -: 4];
  endfunction

  function automatic logic [31:0] perm(input logic [31:0] s);
    logic [31:0] f;
    for (int i = 0; i < 32; i++) f[31-i] = s[32-P_TAB[i]];
    return f;
  endfunction

  function automatic logic [63:0] ref_round(input logic [31:0] l, input logic [31:0] r,
                                            input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] so;
    logic [5:0]  b;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]];
    x = x ^ k;
    so = '0;
    for (int n = 0; n < 8; n++) begin
      b = x[47-6*n -: 6];
      so[31-4*n -: 4] = sbox(n, {b[5], b[0], b[4:1]});
    end
    return {r, l ^ perm(so)};
  endfunction

  // Behavioural S-box instance answering the registered selects
  always_comb begin
    s_in0 = sbox(0, sel_box0);
    s_in1 = sbox(1, sel_box1);
    s_in2 = sbox(2, sel_box2);
    s_in3 = sbox(3, sel_box3);
    s_in4 = sbox(4, sel_box4);
    s_in5 = sbox(5, sel_box5);
    s_in6 = sbox(6, sel_box6);
    s_in7 = sbox(7, sel_box7);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: push model result on input transfer, compare on output transfer
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_lr", {out_l, out_r}, e.lr);
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        e.lr  = ref_round(in_l, in_r, in_key);
        e.tag = in_tag;
        sb.push_back(e);
        n_in++;
      end
    end
  end

  task automatic cycle(output bit a);
    @(negedge clk);
    a = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat(input int tag);
    in_l   = $urandom;
    in_r   = $urandom;
    in_key = {16'($urandom), $urandom};
    in_tag = TAG_W'(tag);
  endtask

  initial begin
    int base, sent, cyc;
    logic [67:0] snap;
    reset_n = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0; in_key = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sel", {16'd0, sel_box0, sel_box1, sel_box2, sel_box3,
                      sel_box4, sel_box5, sel_box6, sel_box7}, 64'd0);
    check("rst_out_data", {out_l, out_r}, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer round
    in_l = 32'hCC00CCFF; in_r = 32'hF0AAF0AA; in_key = 48'h1B02EFFC7072; in_tag = 4'd1;
    in_valid = 1'b1;
    cycle(acc);
    check("kat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    check("kat_sel0", 64'(sel_box0), 64'h0C);
    check("kat_sel1", 64'(sel_box1), 64'h18);
    check("kat_sout", 64'({s_in0, s_in1, s_in2, s_in3, s_in4, s_in5, s_in6, s_in7}), 64'h5C82B597);
    check("kat_lat1_valid", 64'(out_valid), 64'd0);
    cycle(acc);
    check("kat_lat2_valid", 64'(out_valid), 64'd1);
    check("kat_out", {out_l, out_r}, 64'hF0AAF0AA_EF4A6544);
    cycle(acc);

    // All-zero vector
    in_l = '0; in_r = '0; in_key = '0; in_tag = 4'd2; in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    check("zero_sel", {16'd0, sel_box0, sel_box1, sel_box2, sel_box3,
                       sel_box4, sel_box5, sel_box6, sel_box7}, 64'd0);
    check("zero_sout", 64'({s_in0, s_in1, s_in2, s_in3, s_in4, s_in5, s_in6, s_in7}), 64'hEFA72C4D);
    cycle(acc);
    check("zero_out", {out_l, out_r}, {32'd0, perm(32'hEFA72C4D)});
    cycle(acc);

    // Streaming: 16 back-to-back beats
    base = n_out;
    for (int t = 0; t < 16; t++) begin
      new_beat(t);
      in_valid = 1'b1;
      check("stream_in_ready", 64'(in_ready), 64'd1);
      cycle(acc);
    end
    in_valid = 1'b0;
    repeat (3) cycle(acc);
    check("stream_count", 64'(n_out - base), 64'd16);

    // Backpressure: three beats offered while output is stalled
    out_ready = 1'b0;
    base = n_in;
    sent = 0;
    new_beat(8);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle(acc);
      if (acc) begin
        sent++;
        new_beat(8 + sent);
      end
    end
    check("bp_accepted", 64'(n_in - base), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    snap = {out_l, out_r, out_tag};
    repeat (2) cycle(acc);
    check("bp_frozen", 64'({out_l, out_r, out_tag} ^ snap), 64'd0);
    out_ready = 1'b1;
    cyc = 0;
    while (sent < 3 && cyc < 10) begin
      cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    check("bp_third_accepted", 64'(sent), 64'd3);
    in_valid = 1'b0;
    repeat (4) cycle(acc);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Random traffic with random backpressure
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 40000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        new_beat(int'($urandom_range(0, 15)));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("rand_sent", 64'(sent), 64'd10000);
    out_ready = 1'b1;
    repeat (4) cycle(acc);
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    sent = 0;
    cyc = 0;
    new_beat(3);
    in_valid = 1'b1;
    while (sent < 2 && cyc < 10) begin
      cycle(acc);
      if (acc) begin
        sent++;
        new_beat(4);
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("rst_fill_out_valid", 64'(out_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle(acc);
      check("post_rst_no_valid", 64'(out_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
